wb_rr_arbiter: RTL and testbench



---
 rtl/wb_rr_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Four-master to one-slave Wishbone arbiter with round-robin or fixed-priority
// selection, a cycle-long grant, and a watchdog that aborts hung slave cycles.
module wb_rr_arbiter #(
  parameter int unsigned rr_mode        = 1,   // 1 = round-robin, 0 = lowest index wins
  parameter int unsigned timeout_cycles = 255  // stalled-cycle limit, 0 disables, max 65535
) (
  input  logic         clk,
  input  logic         rst,          // asynchronous, active-low

  input  logic [127:0] m_adr_i,
  input  logic [127:0] m_dat_i,
  input  logic [15:0]  m_sel_i,
  input  logic [3:0]   m_we_i,
  input  logic [3:0]   m_cyc_i,
  input  logic [3:0]   m_stb_i,
  output logic [31:0]  m_dat_o,
  output logic [3:0]   m_ack_o,
  output logic [3:0]   m_err_o,

  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  output logic [3:0]   s_sel_o,
  output logic         s_we_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  input  logic [31:0]  s_dat_i,
  input  logic         s_ack_i,
  input  logic         s_err_i,

  output logic [3:0]   gnt_o,
  output logic         timeout_o,
  output logic [1:0]   timeout_id_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_d;
  logic [1:0]  timeout_id_d;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  rr_cand;
  logic        g_cyc;
  logic        stalled;
  logic [16:0] wdog_inc;
  logic        limit_hit;

  assign win_valid = |m_cyc_i;
  assign g_cyc     = m_cyc_i[gnt_idx_q];

  // Scan from the farthest candidate to the nearest so the nearest requester
  // overwrites the result; in round-robin the previous owner is checked last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    win_idx = 2'd0;
    rr_cand = 2'd0;
    if (rr_mode != 0) begin
      for (int k = 4; k >= 1; k--) begin
        rr_cand = last_q + 2'(k);
        if (m_cyc_i[rr_cand]) win_idx = rr_cand;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (m_cyc_i[i]) win_idx = 2'(i);
      end
    end
  end

  // A stalled cycle is a granted strobe with no slave response.
  assign stalled   = (state_q == BUSY) && m_stb_i[gnt_idx_q] && !s_ack_i && !s_err_i;
  assign wdog_inc  = {1'b0, wdog_q} + 17'd1;
  // Abort fires on the stalled cycle that would bring the count to the limit,
  // so a response arriving in that same cycle still wins.
  assign limit_hit = (timeout_cycles != 0) && (wdog_inc == 17'(timeout_cycles));

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_o;
    gnt_idx_d    = gnt_idx_q;
    last_d       = last_q;
    wdog_d       = wdog_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_o;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d     = 4'b0001 << win_idx;
          gnt_idx_d = win_idx;
          wdog_d    = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        if (!g_cyc) begin
          last_d  = gnt_idx_q;
          gnt_d   = '0;
          state_d = IDLE;
        end else if (s_ack_i || s_err_i) begin
          wdog_d = '0;
        end else if (stalled) begin
          if (limit_hit) begin
            state_d      = ABORT;
            timeout_d    = 1'b1;
            timeout_id_d = gnt_idx_q;
            wdog_d       = '0;
          end else begin
            wdog_d = (&wdog_q) ? wdog_q : wdog_inc[15:0];
          end
        end
      end

      ABORT: begin
        state_d = DRAIN;
      end

      DRAIN: begin
        if (!g_cyc) begin
          last_d  = gnt_idx_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Slave side is only driven while BUSY; responses in any other state are dropped.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = s_dat_i;

    case (state_q)
      BUSY: begin
        s_adr_o            = m_adr_i[{gnt_idx_q, 5'd0} +: 32];
        s_dat_o            = m_dat_i[{gnt_idx_q, 5'd0} +: 32];
        s_sel_o            = m_sel_i[{gnt_idx_q, 2'd0} +: 4];
        s_we_o             = m_we_i[gnt_idx_q];
        s_cyc_o            = m_cyc_i[gnt_idx_q];
        s_stb_o            = m_stb_i[gnt_idx_q];
        m_ack_o[gnt_idx_q] = s_ack_i;
        m_err_o[gnt_idx_q] = s_err_i;
      end
      ABORT: begin
        m_err_o[gnt_idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_o        <= '0;
      gnt_idx_q    <= '0;
      last_q       <= 2'd3;
      wdog_q       <= '0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      gnt_o        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      last_q       <= last_d;
      wdog_q       <= wdog_d;
      timeout_o    <= timeout_d;
      timeout_id_o <= timeout_id_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: three instances (round-robin with
// watchdog, fixed priority, watchdog disabled) share one set of bus inputs.
module tb_wb_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] m_adr, m_dat;
  logic [15:0]  m_sel;
  logic [3:0]   m_we, m_cyc, m_stb;
  logic [31:0]  s_dat;
  logic         s_ack, s_err;

  logic [31:0] a_m_dat, b_m_dat, c_m_dat;
  logic [3:0]  a_m_ack, b_m_ack, c_m_ack;
  logic [3:0]  a_m_err, b_m_err, c_m_err;
  logic [31:0] a_s_adr, b_s_adr, c_s_adr;
  logic [31:0] a_s_dat, b_s_dat, c_s_dat;
  logic [3:0]  a_s_sel, b_s_sel, c_s_sel;
  logic        a_s_we, b_s_we, c_s_we;
  logic        a_s_cyc, b_s_cyc, c_s_cyc;
  logic        a_s_stb, b_s_stb, c_s_stb;
  logic [3:0]  a_gnt, b_gnt, c_gnt;
  logic        a_to, b_to, c_to;
  logic [1:0]  a_to_id, b_to_id, c_to_id;

  int vectors = 0;
  int miscompares = 0;

  wb_rr_arbiter #(.rr_mode(1), .timeout_cycles(8)) dut_a (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(a_m_dat), .m_ack_o(a_m_ack), .m_err_o(a_m_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(a_gnt), .timeout_o(a_to), .timeout_id_o(a_to_id)
  );

  wb_rr_arbiter #(.rr_mode(0), .timeout_cycles(8)) dut_b (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(b_m_dat), .m_ack_o(b_m_ack), .m_err_o(b_m_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(b_gnt), .timeout_o(b_to), .timeout_id_o(b_to_id)
  );

  wb_rr_arbiter #(.rr_mode(1), .timeout_cycles(0)) dut_c (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(c_m_dat), .m_ack_o(c_m_ack), .m_err_o(c_m_err),
    .s_adr_o(c_s_adr), .s_dat_o(c_s_dat), .s_sel_o(c_s_sel), .s_we_o(c_s_we),
    .s_cyc_o(c_s_cyc), .s_stb_o(c_s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(c_gnt), .timeout_o(c_to), .timeout_id_o(c_to_id)
  );

  // Reference arbitration: first requester after the last owner, wrapping 3->0.
  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int fp_pick(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc[k]          = cyc;
    m_stb[k]          = stb;
    m_we[k]           = we;
    m_adr[32*k +: 32] = adr;
    m_dat[32*k +: 32] = dat;
    m_sel[4*k +: 4]   = sel;
  endtask

  task automatic idle_bus();
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    m_adr = '0; m_dat = '0; m_sel = '0; s_dat = '0;
    idle_bus();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    vectors++; if (a_gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", a_gnt); end
    vectors++; if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_s_we !== 1'b0) begin miscompares++; $display("FAIL reset_slave_ctl: got cyc=%b stb=%b we=%b expected 0", a_s_cyc, a_s_stb, a_s_we); end
    vectors++; if (a_to !== 1'b0 || a_to_id !== 2'd0) begin miscompares++; $display("FAIL reset_timeout: got %b/%0d expected 0/0", a_to, a_to_id); end
    vectors++; if (a_m_ack !== 4'b0 || a_m_err !== 4'b0) begin miscompares++; $display("FAIL reset_resp: got ack=%b err=%b expected 0", a_m_ack, a_m_err); end
    vectors++; if (a_s_adr !== 32'd0 || a_s_sel !== 4'd0) begin miscompares++; $display("FAIL reset_adr: got %h/%h expected 0", a_s_adr, a_s_sel); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    s_ack = 1'b1; s_err = 1'b1;
    sample();
    vectors++; if (a_m_ack !== 4'b0 || a_m_err !== 4'b0) begin miscompares++; $display("FAIL idle_resp_ignored: got ack=%b err=%b expected 0", a_m_ack, a_m_err); end
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h1000_0040, 32'h0, 4'hF);
    sample();
    vectors++; if (a_s_cyc !== 1'b0) begin miscompares++; $display("FAIL single_cyc_early: got %b expected 0", a_s_cyc); end
    tick(); sample();
    vectors++; if (a_s_cyc !== 1'b1 || a_gnt !== 4'b0010) begin miscompares++; $display("FAIL single_grant: got cyc=%b gnt=%b expected 1/0010", a_s_cyc, a_gnt); end
    vectors++; if (a_s_adr !== 32'h1000_0040 || a_s_sel !== 4'hF) begin miscompares++; $display("FAIL single_adr: got %h/%h expected 10000040/f", a_s_adr, a_s_sel); end
    tick(); sample();
    vectors++; if (a_m_ack !== 4'b0) begin miscompares++; $display("FAIL single_no_early_ack: got %b expected 0000", a_m_ack); end
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    sample();
    vectors++; if (a_m_ack !== 4'b0010 || a_m_err !== 4'b0) begin miscompares++; $display("FAIL single_ack: got ack=%b err=%b expected 0010/0000", a_m_ack, a_m_err); end
    vectors++; if (a_m_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_rdata: got %h expected deadbeef", a_m_dat); end
    tick();
    s_ack = 1'b0;
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample();
    vectors++; if (a_m_ack !== 4'b0) begin miscompares++; $display("FAIL single_ack_once: got %b expected 0000", a_m_ack); end
    tick(); sample();
    vectors++; if (a_gnt !== 4'b0) begin miscompares++; $display("FAIL single_release: got %b expected 0000", a_gnt); end
  endtask

  task automatic test_rr_rotation();
    int last;
    int exp;
    logic [3:0] exp_g;
    do_reset();
    last = 3;
    for (int k = 0; k < 4; k++) set_master(k, 1'b1, 1'b1, 1'b0, 32'(k * 16), 32'h0, 4'hF);
    tick(); sample();
    for (int n = 0; n < 5; n++) begin
      exp   = rr_pick(last, 4'hF);
      exp_g = 4'b0001 << exp;
      vectors++; if (a_gnt !== exp_g) begin miscompares++; $display("FAIL rr_order[%0d]: got %b expected %b", n, a_gnt, exp_g); end
      tick();
      s_ack = 1'b1;
      sample();
      vectors++; if (a_m_ack !== exp_g) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b expected %b", n, a_m_ack, exp_g); end
      tick();
      s_ack = 1'b0;
      m_cyc[exp] = 1'b0; m_stb[exp] = 1'b0;
      last = exp;
      tick();
      m_cyc[exp] = 1'b1; m_stb[exp] = 1'b1;
      sample();
      vectors++; if (a_gnt !== 4'b0) begin miscompares++; $display("FAIL rr_dead_cycle[%0d]: got %b expected 0000", n, a_gnt); end
      tick(); sample();
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp_b, exp_a;
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    set_master(3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    tick(); sample();
    exp_b = 4'b0001 << fp_pick(4'b1010);
    vectors++; if (b_gnt !== exp_b) begin miscompares++; $display("FAIL fp_first: got %b expected %b", b_gnt, exp_b); end
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h000, 32'h0, 4'hF);
    sample();
    vectors++; if (b_gnt !== exp_b) begin miscompares++; $display("FAIL fp_hold_join: got %b expected %b", b_gnt, exp_b); end
    tick(); sample();
    vectors++; if (b_gnt !== exp_b || b_s_adr !== 32'h100) begin miscompares++; $display("FAIL fp_hold: got %b/%h expected %b/100", b_gnt, b_s_adr, exp_b); end
    tick();
    s_ack = 1'b1;
    sample();
    vectors++; if (b_m_ack !== exp_b) begin miscompares++; $display("FAIL fp_ack: got %b expected %b", b_m_ack, exp_b); end
    tick();
    s_ack = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(); sample();
    vectors++; if (b_gnt !== 4'b0) begin miscompares++; $display("FAIL fp_dead_cycle: got %b expected 0000", b_gnt); end
    tick(); sample();
    exp_b = 4'b0001 << fp_pick(4'b1001);
    exp_a = 4'b0001 << rr_pick(1, 4'b1001);
    vectors++; if (b_gnt !== exp_b) begin miscompares++; $display("FAIL fp_second: got %b expected %b", b_gnt, exp_b); end
    vectors++; if (a_gnt !== exp_a) begin miscompares++; $display("FAIL rr_second: got %b expected %b", a_gnt, exp_a); end
  endtask

  task automatic test_timeout();
    int bad;
    logic [3:0] exp_g;
    do_reset();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    tick(); sample();
    vectors++; if (a_gnt !== 4'b0100) begin miscompares++; $display("FAIL to_grant: got %b expected 0100", a_gnt); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_m_err !== 4'b0 || a_to !== 1'b0 || a_s_cyc !== 1'b1) bad++;
      tick(); sample();
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL to_stall_window: got %0d bad cycles expected 0", bad); end
    vectors++; if (a_m_err !== 4'b0100 || a_m_ack !== 4'b0) begin miscompares++; $display("FAIL to_err: got err=%b ack=%b expected 0100/0000", a_m_err, a_m_ack); end
    vectors++; if (a_to !== 1'b1 || a_s_cyc !== 1'b0 || a_s_stb !== 1'b0) begin miscompares++; $display("FAIL to_pulse: got to=%b cyc=%b stb=%b expected 1/0/0", a_to, a_s_cyc, a_s_stb); end
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h000, 32'h0, 4'hF);
    s_ack = 1'b1;
    sample();
    vectors++; if (a_to !== 1'b0 || a_to_id !== 2'd2) begin miscompares++; $display("FAIL to_id: got to=%b id=%0d expected 0/2", a_to, a_to_id); end
    vectors++; if (a_m_ack !== 4'b0 || a_m_err !== 4'b0) begin miscompares++; $display("FAIL drain_resp_ignored: got ack=%b err=%b expected 0", a_m_ack, a_m_err); end
    tick();
    s_ack = 1'b0;
    tick(); sample();
    vectors++; if (a_gnt !== 4'b0100 || a_s_cyc !== 1'b0) begin miscompares++; $display("FAIL drain_hold: got gnt=%b cyc=%b expected 0100/0", a_gnt, a_s_cyc); end
    tick();
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick(); sample();
    vectors++; if (a_gnt !== 4'b0) begin miscompares++; $display("FAIL drain_release: got %b expected 0000", a_gnt); end
    tick(); sample();
    exp_g = 4'b0001 << rr_pick(2, 4'b0001);
    vectors++; if (a_gnt !== exp_g) begin miscompares++; $display("FAIL to_next_grant: got %b expected %b", a_gnt, exp_g); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    tick();
    repeat (7) tick();
    s_ack = 1'b1;
    sample();
    vectors++; if (a_m_ack !== 4'b0100 || a_m_err !== 4'b0 || a_to !== 1'b0) begin miscompares++; $display("FAIL limit_ack: got ack=%b err=%b to=%b expected 0100/0000/0", a_m_ack, a_m_err, a_to); end
    tick();
    s_ack = 1'b0;
    sample();
    vectors++; if (a_to !== 1'b0 || a_m_err !== 4'b0 || a_s_cyc !== 1'b1) begin miscompares++; $display("FAIL limit_no_abort: got to=%b err=%b cyc=%b expected 0/0000/1", a_to, a_m_err, a_s_cyc); end
    tick(); tick(); sample();
    vectors++; if (a_s_cyc !== 1'b1 || a_gnt !== 4'b0100) begin miscompares++; $display("FAIL limit_restart: got cyc=%b gnt=%b expected 1/0100", a_s_cyc, a_gnt); end
  endtask

  task automatic test_no_timeout();
    int bad;
    do_reset();
    set_master(3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
    tick();
    bad = 0;
    repeat (1000) begin
      sample();
      if (c_to !== 1'b0 || c_m_err !== 4'b0 || c_gnt !== 4'b1000 || c_s_cyc !== 1'b1) bad++;
      tick();
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL no_timeout_stall: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_g;
    do_reset();
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 4'h3);
    tick(); sample();
    vectors++; if (a_s_cyc !== 1'b1 || a_s_we !== 1'b1 || a_s_dat !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ar_write: got cyc=%b we=%b dat=%h expected 1/1/cafef00d", a_s_cyc, a_s_we, a_s_dat); end
    tick();
    s_ack = 1'b1;
    #1 rst = 1'b0;
    #1;
    vectors++; if (a_gnt !== 4'b0 || a_s_cyc !== 1'b0) begin miscompares++; $display("FAIL ar_async: got gnt=%b cyc=%b expected 0000/0", a_gnt, a_s_cyc); end
    vectors++; if (a_m_ack !== 4'b0 || a_m_err !== 4'b0) begin miscompares++; $display("FAIL ar_resp: got ack=%b err=%b expected 0", a_m_ack, a_m_err); end
    tick(); tick();
    idle_bus();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    rst = 1'b1;
    tick(); sample();
    exp_g = 4'b0001 << rr_pick(3, 4'b0011);
    vectors++; if (a_gnt !== exp_g) begin miscompares++; $display("FAIL ar_first_grant: got %b expected %b", a_gnt, exp_g); end
  endtask

  task automatic test_random();
    int last;
    int exp;
    int d;
    logic [3:0] mask, remaining, exp_g;
    logic [1:0] rtype;
    logic [31:0] adr_m [4];
    logic [31:0] dat_m [4];
    logic [3:0]  sel_m [4];
    logic        we_m  [4];
    do_reset();
    last = 3;
    for (int r = 0; r < 20; r++) begin
      tick();
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) begin
        adr_m[k] = $urandom; dat_m[k] = $urandom;
        sel_m[k] = 4'($urandom_range(1, 15)); we_m[k] = 1'($urandom_range(0, 1));
        if (mask[k]) set_master(k, 1'b1, 1'b1, we_m[k], adr_m[k], dat_m[k], sel_m[k]);
      end
      remaining = mask;
      while (remaining != 4'b0) begin
        tick(); sample();
        exp   = rr_pick(last, remaining);
        exp_g = 4'b0001 << exp;
        vectors++; if (a_gnt !== exp_g) begin miscompares++; $display("FAIL rand_gnt r%0d: got %b expected %b", r, a_gnt, exp_g); end
        vectors++; if (a_s_adr !== adr_m[exp] || a_s_dat !== dat_m[exp] || a_s_sel !== sel_m[exp] || a_s_we !== we_m[exp]) begin
          miscompares++; $display("FAIL rand_mux r%0d: got %h/%h/%h/%b expected %h/%h/%h/%b", r, a_s_adr, a_s_dat, a_s_sel, a_s_we, adr_m[exp], dat_m[exp], sel_m[exp], we_m[exp]);
        end
        d = $urandom_range(0, 3);
        repeat (d) tick();
        tick();
        rtype = 2'($urandom_range(1, 3));
        s_ack = rtype[0]; s_err = rtype[1]; s_dat = $urandom;
        sample();
        vectors++; if (a_m_ack !== (rtype[0] ? exp_g : 4'b0) || a_m_err !== (rtype[1] ? exp_g : 4'b0)) begin
          miscompares++; $display("FAIL rand_resp r%0d: got ack=%b err=%b expected ack=%b err=%b", r, a_m_ack, a_m_err, rtype[0] ? exp_g : 4'b0, rtype[1] ? exp_g : 4'b0);
        end
        vectors++; if (a_m_dat !== s_dat) begin miscompares++; $display("FAIL rand_rdata r%0d: got %h expected %h", r, a_m_dat, s_dat); end
        tick();
        s_ack = 1'b0; s_err = 1'b0;
        m_cyc[exp] = 1'b0; m_stb[exp] = 1'b0;
        remaining[exp] = 1'b0;
        last = exp;
        tick(); sample();
        vectors++; if (a_gnt !== 4'b0) begin miscompares++; $display("FAIL rand_dead r%0d: got %b expected 0000", r, a_gnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_rotation();
    test_fixed_priority();
    test_timeout();
    test_ack_at_limit();
    test_no_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
